if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have ports clk input 1 (clock) and rst input 1 (reset, asynchronous, active-high).
REQ-002 SHALL have pc_i input 32 (current PC from PC register) and pc4_i input 32 (pc_i+4 from PC register).
REQ-003 SHALL have keep_o output 1 (hold PC register) and pc_next_o output 32 (next PC value).
REQ-004 SHALL have redirect_i input 1 (branch/jump taken) and redirect_target_i input 32 (target address).
REQ-005 SHALL have imem_req_o output 1, imem_addr_o output 32, imem_ack_i input 1 and imem_rdata_i input 32 (instruction memory port).
REQ-006 SHALL have id_stall_i input 1 (decode not accepting), inst_valid_o output 1, inst_o output 32 and inst_pc_o output 32 (to IF/ID).
REQ-007 SHALL have parameters BUF_DEPTH = 2 (fetch buffer entries) and RESET_PC = 32'h00400000 (reset fetch address).

Function
REQ-008 SHALL implement FSM states IDLE (no request outstanding), BUSY (request outstanding, data kept) and DROP (request outstanding, data discarded).
REQ-009 SHALL drive imem_req_o = 1 in BUSY and DROP and 0 in IDLE, with at most one request outstanding.
REQ-010 SHALL drive imem_addr_o from register addr_q, stable from launch until the ack cycle.
REQ-011 SHALL complete a request in the cycle imem_req_o & imem_ack_i = 1, sampling imem_rdata_i in that cycle.
REQ-012 SHALL define push = ack in BUSY with no redirect_i, and pop = inst_valid_o & ~id_stall_i.
REQ-013 SHALL launch when no redirect_i and (state IDLE or ack this cycle) and (count - pop + push) < BUF_DEPTH.
REQ-014 SHALL, on launch, load addr_q <= pc_i and enter BUSY.
REQ-015 SHALL, on ack without launch, enter IDLE.
REQ-016 SHALL drive keep_o = ~(launch | redirect_i).
REQ-017 SHALL drive pc_next_o = redirect_i ? redirect_target_i : pc4_i.
REQ-018 SHALL, on push, write {addr_q, imem_rdata_i} to the buffer tail; on pop, advance the head; simultaneous push and pop SHALL leave count unchanged.
REQ-019 SHALL drive inst_valid_o = (count != 0), with inst_o and inst_pc_o taken from the head entry, all from registers.
REQ-020 SHALL, on redirect_i, clear the buffer (count 0, valid low next cycle) and launch nothing that cycle.
REQ-021 SHALL, on redirect_i, go to DROP if a request is outstanding and not acked that cycle, otherwise to IDLE.
REQ-022 SHALL, in DROP, discard the acked data and go to IDLE; redirect_i in DROP SHALL keep the state DROP.
REQ-023 SHALL never write to a full buffer; an ack with count = BUF_DEPTH and no pop is unreachable by REQ-013.

Reset
REQ-024 SHALL, on rst, set state IDLE, count 0, head/tail 0, addr_q RESET_PC, imem_req_o 0, inst_valid_o 0, inst_o 0 and inst_pc_o 0.
REQ-025 SHALL, on rst asserted mid-request, abandon the request; a late ack while in IDLE SHALL be ignored.

Structure
REQ-026 SHALL place the state encoding and RESET_PC in shared package cpu_pkg.
REQ-027 SHALL implement the buffer as sub-module fetch_fifo (2 entries x 64 bits, with push, pop, flush, count).

Verification
REQ-028 Bench: reset release, ack always 1 -> first req addr 0x00400000, then one instruction per cycle with addresses 0x00400000, 0x00400004, 0x00400008 and keep_o = 0.
REQ-029 Bench: id_stall_i = 1 with ack always 1 -> count saturates at 2, imem_req_o falls, keep_o = 1 and the PC stays at 0x0040000C.
REQ-030 Bench: ack delayed 3 cycles -> imem_addr_o stable 3 cycles, keep_o = 1 while waiting, data pushed in the ack cycle.
REQ-031 Bench: redirect_i to 0x00400100 while a request is outstanding -> DROP, buffer flushed, stale data discarded, next fetch addr 0x00400100.
REQ-032 Bench: redirect_i in the ack cycle -> acked data discarded, state IDLE, next cycle launch at 0x00400100.
REQ-033 Bench: rst pulse during BUSY -> outputs take their reset values, and the next launch is at 0x00400000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM encoding, reset vector and fetch buffer entry.
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_BUSY = 2'd1,  // request outstanding, response will be buffered
    ST_DROP = 2'd2   // request outstanding, response belongs to a squashed path
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small show-ahead FIFO holding fetched {pc, instruction} pairs; head entry is read straight from registers.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head_data,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t        mem_reg [DEPTH];
  logic [PTR_W-1:0]    head_reg;
  logic [PTR_W-1:0]    tail_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                full;
  logic                empty;
  logic                push_en;
  logic                pop_en;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Flush dominates; a push into a full buffer is only accepted when the head leaves the same cycle.
  assign push_en = push & ~flush & (~full | pop);
  assign pop_en  = pop & ~flush & ~empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push_en && (tail_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_en) begin
        tail_reg <= ptr_inc(tail_reg);
      end
      if (pop_en) begin
        head_reg <= ptr_inc(head_reg);
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem_reg[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, PC hold/advance, redirect squash and a fetch buffer to IF/ID.
module if_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  output logic        keep_o,
  output logic [31:0] pc_next_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        id_stall_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e       state_reg;
  fetch_state_e       state_next;
  logic [31:0]        addr_q;
  logic               ack;
  logic               push;
  logic               pop;
  logic               launch;
  logic [CNT_W-1:0]   buf_count;
  logic [CNT_W:0]     count_after;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;

  // Requests only complete while one is actually outstanding, so a late ack after reset is ignored.
  assign ack  = imem_req_o & imem_ack_i;
  assign push = ack & (state_reg == ST_BUSY) & ~redirect_i;
  assign pop  = inst_valid_o & ~id_stall_i;

  assign count_after = ({1'b0, buf_count} + (CNT_W + 1)'(push)) - (CNT_W + 1)'(pop);
  assign launch = ~redirect_i
                & ((state_reg == ST_IDLE) | ack)
                & (count_after < (CNT_W + 1)'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_q    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        addr_q <= pc_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (redirect_i) begin
          state_next = ack ? ST_IDLE : ST_DROP;
        end else if (ack) begin
          state_next = launch ? ST_BUSY : ST_IDLE;
        end
      end
      ST_DROP: begin
        // The squashed response is thrown away; a fresh request may go out in the same ack cycle.
        if (ack) begin
          state_next = launch ? ST_BUSY : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = (state_reg != ST_IDLE);
    imem_addr_o = addr_q;
    keep_o      = ~(launch | redirect_i);
    pc_next_o   = redirect_i ? redirect_target_i : pc4_i;
  end

  assign push_entry.pc   = addr_q;
  assign push_entry.inst = imem_rdata_i;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_i),
    .head_data (head_entry),
    .count     (buf_count)
  );

  assign inst_valid_o = (buf_count != '0);
  assign inst_o       = head_entry.inst;
  assign inst_pc_o    = head_entry.pc;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: streaming fetch, decode stall, slow memory, redirects and mid-request reset.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        keep;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_ctrl #(
    .BUF_DEPTH (2),
    .RESET_PC  (32'h0040_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc),
    .pc4_i             (pc4),
    .keep_o            (keep),
    .pc_next_o         (pc_next),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .imem_req_o        (imem_req),
    .imem_addr_o       (imem_addr),
    .imem_ack_i        (imem_ack),
    .imem_rdata_i      (imem_rdata),
    .id_stall_i        (id_stall),
    .inst_valid_o      (inst_valid),
    .inst_o            (inst),
    .inst_pc_o         (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register owned by the pipeline, and a memory whose word at address A is ~A.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0040_0000;
    else if (!keep) pc <= pc_next;
  end
  assign pc4        = pc + 32'd4;
  assign imem_rdata = ~imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; redirect_target = '0; id_stall = 1'b0;
    tick(); tick();
    #1;
    $display("reset: req=%b valid=%b addr=%h", imem_req, inst_valid, imem_addr);
    chk("rst_req",     {31'd0, imem_req},   32'd0);
    chk("rst_valid",   {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",    inst,                32'd0);
    chk("rst_inst_pc", inst_pc,             32'd0);
    chk("rst_addr",    imem_addr,           32'h0040_0000);

    // Streaming with ack always high.
    rst = 1'b0; imem_ack = 1'b1;
    #1;
    $display("C0: req=%b keep=%b pc_next=%h", imem_req, keep, pc_next);
    chk("c0_req",     {31'd0, imem_req}, 32'd0);
    chk("c0_keep",    {31'd0, keep},     32'd0);
    chk("c0_pc_next", pc_next,           32'h0040_0004);
    tick(); #1;
    $display("C1: req=%b addr=%h valid=%b", imem_req, imem_addr, inst_valid);
    chk("c1_req",   {31'd0, imem_req},   32'd1);
    chk("c1_addr",  imem_addr,           32'h0040_0000);
    chk("c1_valid", {31'd0, inst_valid}, 32'd0);
    chk("c1_keep",  {31'd0, keep},       32'd0);
    tick(); #1;
    $display("C2: valid=%b inst_pc=%h inst=%h addr=%h", inst_valid, inst_pc, inst, imem_addr);
    chk("c2_valid",   {31'd0, inst_valid}, 32'd1);
    chk("c2_inst_pc", inst_pc,             32'h0040_0000);
    chk("c2_inst",    inst,                32'hFFBF_FFFF);
    chk("c2_addr",    imem_addr,           32'h0040_0004);
    chk("c2_keep",    {31'd0, keep},       32'd0);

    // Decode stalls: the buffer fills to two entries and fetch stops.
    tick(); id_stall = 1'b1; #1;
    $display("C3: inst_pc=%h inst=%h addr=%h keep=%b", inst_pc, inst, imem_addr, keep);
    chk("c3_inst_pc", inst_pc,       32'h0040_0004);
    chk("c3_inst",    inst,          32'hFFBF_FFFB);
    chk("c3_addr",    imem_addr,     32'h0040_0008);
    chk("c3_keep",    {31'd0, keep}, 32'd1);
    chk("c3_pc",      pc,            32'h0040_000C);
    tick(); #1;
    $display("C4: req=%b keep=%b pc=%h", imem_req, keep, pc);
    chk("c4_req",     {31'd0, imem_req}, 32'd0);
    chk("c4_keep",    {31'd0, keep},     32'd1);
    chk("c4_inst_pc", inst_pc,           32'h0040_0004);
    chk("c4_pc",      pc,                32'h0040_000C);
    tick(); #1;
    $display("C5: req=%b keep=%b pc=%h", imem_req, keep, pc);
    chk("c5_req",  {31'd0, imem_req}, 32'd0);
    chk("c5_pc",   pc,                32'h0040_000C);

    // Stall released, memory answers three cycles after launch.
    tick(); id_stall = 1'b0; imem_ack = 1'b0; #1;
    $display("C6: keep=%b inst_pc=%h", keep, inst_pc);
    chk("c6_keep",    {31'd0, keep}, 32'd0);
    chk("c6_inst_pc", inst_pc,       32'h0040_0004);
    tick(); #1;
    $display("C7: req=%b addr=%h keep=%b inst_pc=%h", imem_req, imem_addr, keep, inst_pc);
    chk("c7_req",     {31'd0, imem_req}, 32'd1);
    chk("c7_addr",    imem_addr,         32'h0040_000C);
    chk("c7_keep",    {31'd0, keep},     32'd1);
    chk("c7_inst_pc", inst_pc,           32'h0040_0008);
    tick(); #1;
    $display("C8: addr=%h keep=%b valid=%b", imem_addr, keep, inst_valid);
    chk("c8_addr",  imem_addr,           32'h0040_000C);
    chk("c8_keep",  {31'd0, keep},       32'd1);
    chk("c8_valid", {31'd0, inst_valid}, 32'd0);
    tick(); imem_ack = 1'b1; #1;
    $display("C9: addr=%h keep=%b", imem_addr, keep);
    chk("c9_addr", imem_addr,     32'h0040_000C);
    chk("c9_keep", {31'd0, keep}, 32'd0);

    // Redirect while a request is outstanding.
    tick(); imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h0040_0100; #1;
    $display("C10: inst_pc=%h inst=%h keep=%b pc_next=%h", inst_pc, inst, keep, pc_next);
    chk("c10_inst_pc", inst_pc,       32'h0040_000C);
    chk("c10_inst",    inst,          32'hFFBF_FFF3);
    chk("c10_keep",    {31'd0, keep}, 32'd0);
    chk("c10_pc_next", pc_next,       32'h0040_0100);
    tick(); redirect = 1'b0; #1;
    $display("C11: valid=%b req=%b addr=%h keep=%b pc=%h", inst_valid, imem_req, imem_addr, keep, pc);
    chk("c11_valid", {31'd0, inst_valid}, 32'd0);
    chk("c11_req",   {31'd0, imem_req},   32'd1);
    chk("c11_addr",  imem_addr,           32'h0040_0010);
    chk("c11_keep",  {31'd0, keep},       32'd1);
    chk("c11_pc",    pc,                  32'h0040_0100);
    tick(); imem_ack = 1'b1; #1;
    $display("C12: keep=%b addr=%h", keep, imem_addr);
    chk("c12_keep", {31'd0, keep}, 32'd0);
    chk("c12_addr", imem_addr,     32'h0040_0010);

    // Redirect in the ack cycle of the new request.
    tick(); redirect = 1'b1; redirect_target = 32'h0040_0100; #1;
    $display("C13: valid=%b addr=%h keep=%b", inst_valid, imem_addr, keep);
    chk("c13_valid", {31'd0, inst_valid}, 32'd0);
    chk("c13_addr",  imem_addr,           32'h0040_0100);
    chk("c13_keep",  {31'd0, keep},       32'd0);
    tick(); redirect = 1'b0; imem_ack = 1'b0; #1;
    $display("C14: req=%b valid=%b keep=%b", imem_req, inst_valid, keep);
    chk("c14_req",   {31'd0, imem_req},   32'd0);
    chk("c14_valid", {31'd0, inst_valid}, 32'd0);
    chk("c14_keep",  {31'd0, keep},       32'd0);
    tick(); #1;
    $display("C15: req=%b addr=%h", imem_req, imem_addr);
    chk("c15_req",  {31'd0, imem_req}, 32'd1);
    chk("c15_addr", imem_addr,         32'h0040_0100);

    // Reset pulse in the middle of a request, then a late ack while idle.
    tick(); rst = 1'b1; #1;
    $display("C16: req=%b valid=%b inst=%h inst_pc=%h addr=%h", imem_req, inst_valid, inst, inst_pc, imem_addr);
    chk("c16_req",     {31'd0, imem_req},   32'd0);
    chk("c16_valid",   {31'd0, inst_valid}, 32'd0);
    chk("c16_inst",    inst,                32'd0);
    chk("c16_inst_pc", inst_pc,             32'd0);
    chk("c16_addr",    imem_addr,           32'h0040_0000);
    tick(); rst = 1'b0; imem_ack = 1'b1; #1;
    $display("C17: req=%b keep=%b", imem_req, keep);
    chk("c17_req",  {31'd0, imem_req}, 32'd0);
    chk("c17_keep", {31'd0, keep},     32'd0);
    tick(); #1;
    $display("C18: req=%b addr=%h valid=%b", imem_req, imem_addr, inst_valid);
    chk("c18_req",   {31'd0, imem_req},   32'd1);
    chk("c18_addr",  imem_addr,           32'h0040_0000);
    chk("c18_valid", {31'd0, inst_valid}, 32'd0);
    tick(); #1;
    $display("C19: valid=%b inst_pc=%h inst=%h", inst_valid, inst_pc, inst);
    chk("c19_valid",   {31'd0, inst_valid}, 32'd1);
    chk("c19_inst_pc", inst_pc,             32'h0040_0000);
    chk("c19_inst",    inst,                32'hFFBF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
